// File: rtl/pe_sched_pkg.sv
// Shared types and helpers for the PE array scheduling controller:
// sequencer states, column region codes, column classification and port widths.
package pe_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_DS,
      S_MIX,
      S_FS,
      S_DONE
   } sched_state_e;

   localparam logic [1:0] REG_DS   = 2'd0;
   localparam logic [1:0] REG_MIX  = 2'd1;
   localparam logic [1:0] REG_FS   = 2'd2;
   localparam logic [1:0] REG_NONE = 2'd3;

   function automatic int cw_width(input int n_col);
      return $clog2(n_col + 1);
   endfunction

   function automatic int rw_width(input int mix_rows, input int fs_rows);
      return $clog2(((mix_rows > fs_rows) ? mix_rows : fs_rows) + 1);
   endfunction

   // Columns next to the full-sampled band are transition columns.
   function automatic logic [1:0] col_class(input int col, input int c_lo, input int c_hi);
      if (col >= c_lo && col <= c_hi) begin
         return REG_FS;
      end
      if (col == c_lo - 1 || col == c_hi + 1) begin
         return REG_MIX;
      end
      return REG_DS;
   endfunction

   function automatic sched_state_e state_of_region(input logic [1:0] reg_code);
      case (reg_code)
         REG_MIX: return S_MIX;
         REG_FS:  return S_FS;
         default: return S_DS;
      endcase
   endfunction

   function automatic logic [1:0] region_of_state(input sched_state_e st);
      case (st)
         S_DS:    return REG_DS;
         S_MIX:   return REG_MIX;
         S_FS:    return REG_FS;
         default: return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/pe_row_pattern.sv
// Combinational decode of one PE row: (region, pass, row) -> per-row array controls.
// Outside a search region it yields the idle values (cb_select=1, everything else 0).
module pe_row_pattern
   import pe_sched_pkg::*;
#(
   parameter int DS_ROWS = 38,
   parameter int RW      = 7
) (
   input  logic [1:0]    region_i,
   input  logic [1:0]    pass_i,
   input  logic [RW-1:0] row_i,
   output logic          cb_select_o,
   output logic [1:0]    abs_control_o,
   output logic          change_ref_o,
   output logic          ref_input_control_o
);

   logic [1:0] base;
   int         row_int;

   always_comb begin
      row_int             = int'(row_i);
      base                = {pass_i[0], 1'b0};
      cb_select_o         = 1'b1;
      abs_control_o       = 2'd0;
      change_ref_o        = 1'b0;
      ref_input_control_o = 1'b0;
      case (region_i)
         REG_DS, REG_MIX: begin
            cb_select_o         = (pass_i == 2'd0);
            ref_input_control_o = 1'b1;
            if (row_int < 8) begin
               abs_control_o = base;
               change_ref_o  = 1'b1;
            end else if (row_int < DS_ROWS - 4) begin
               // Interleaved region: even rows compute, odd rows shift.
               abs_control_o = row_i[0] ? base : (base | 2'd1);
               change_ref_o  = row_i[0];
            end else if (row_int < DS_ROWS) begin
               abs_control_o = base | 2'd1;
               change_ref_o  = 1'b1;
            end else begin
               abs_control_o       = base | 2'd1;
               change_ref_o        = 1'b1;
               ref_input_control_o = 1'b0;
            end
         end
         REG_FS: begin
            cb_select_o         = 1'b0;
            abs_control_o       = pass_i;
            change_ref_o        = 1'b1;
            ref_input_control_o = (row_int < 4);
         end
         default: begin
            cb_select_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/pe_array_sched_ctrl.sv
// PE array sequencing controller: preloads the current block, then walks the search
// window column by column emitting registered per-row PE controls, with stall and abort.
module pe_array_sched_ctrl
   import pe_sched_pkg::*;
#(
   parameter int N_COL      = 32,
   parameter int PRE_CYCLES = 64,
   parameter int DS_ROWS    = 38,
   parameter int MIX_ROWS   = 66,
   parameter int FS_ROWS    = 21,
   parameter int N_SUBBLK   = 4,
   parameter int C_LO       = 9,
   parameter int C_HI       = 15
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic                                   stall,
   input  logic                                   abort,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   out_valid,
   output logic                                   in_curr_enable,
   output logic                                   cb_select,
   output logic [1:0]                             abs_control,
   output logic                                   change_ref,
   output logic                                   ref_input_control,
   output logic [1:0]                             region,
   output logic [cw_width(N_COL)-1:0]             search_column_count,
   output logic [rw_width(MIX_ROWS, FS_ROWS)-1:0] search_row_count
);

   localparam int CW = cw_width(N_COL);
   localparam int RW = rw_width(MIX_ROWS, FS_ROWS);
   localparam int PW = $clog2(PRE_CYCLES);

   localparam logic [RW-1:0] DS_LAST      = RW'(DS_ROWS - 1);
   localparam logic [RW-1:0] MIX_LAST     = RW'(MIX_ROWS - 1);
   localparam logic [RW-1:0] FS_LAST      = RW'(FS_ROWS - 1);
   localparam logic [1:0]    FS_PASS_LAST = 2'(N_SUBBLK - 1);
   localparam logic [CW-1:0] COL_LAST     = CW'(N_COL - 1);
   localparam logic [PW-1:0] PRE_LAST     = PW'(PRE_CYCLES - 1);
   localparam logic [PW-1:0] PRE_HALF     = PW'(PRE_CYCLES / 2);

   sched_state_e  state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [1:0]    pass_q, pass_d;
   logic [PW-1:0] pre_q, pre_d;

   logic          hold;
   logic [RW-1:0] row_last;
   logic [1:0]    pass_last;
   logic [1:0]    region_d;
   logic          pat_cb, pat_cr, pat_ri;
   logic [1:0]    pat_abs;

   logic          busy_q, done_q, valid_q, ice_q, cb_q, cr_q, ri_q;
   logic [1:0]    abs_q, region_q;
   logic [CW-1:0] col_out_q;
   logic [RW-1:0] row_out_q;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      pass_d    = pass_q;
      pre_d     = pre_q;
      hold      = 1'b0;
      row_last  = (state_q == S_FS) ? FS_LAST : ((state_q == S_MIX) ? MIX_LAST : DS_LAST);
      pass_last = (state_q == S_FS) ? FS_PASS_LAST : 2'd1;
      if (state_q != S_IDLE && abort) begin
         state_d = S_IDLE;
         col_d   = '0;
         row_d   = '0;
         pass_d  = '0;
         pre_d   = '0;
      end else if (state_q != S_IDLE && stall) begin
         hold = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_PRE;
                  pre_d   = '0;
               end
            end
            S_PRE: begin
               if (pre_q == PRE_LAST) begin
                  state_d = state_of_region(col_class(0, C_LO, C_HI));
                  col_d   = '0;
                  row_d   = '0;
                  pass_d  = '0;
               end else begin
                  pre_d = pre_q + PW'(1);
               end
            end
            S_DS, S_MIX, S_FS: begin
               if (row_q != row_last) begin
                  row_d = row_q + RW'(1);
               end else begin
                  row_d = '0;
                  if (pass_q != pass_last) begin
                     pass_d = pass_q + 2'd1;
                  end else begin
                     // Column finished: next column starts on the following cycle, no bubble.
                     pass_d = '0;
                     if (col_q == COL_LAST) begin
                        state_d = S_DONE;
                     end else begin
                        col_d   = col_q + CW'(1);
                        state_d = state_of_region(col_class(int'(col_q) + 1, C_LO, C_HI));
                     end
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      region_d = region_of_state(state_d);
   end

   pe_row_pattern #(
      .DS_ROWS(DS_ROWS),
      .RW     (RW)
   ) u_row_pattern (
      .region_i           (region_d),
      .pass_i             (pass_d),
      .row_i              (row_d),
      .cb_select_o        (pat_cb),
      .abs_control_o      (pat_abs),
      .change_ref_o       (pat_cr),
      .ref_input_control_o(pat_ri)
   );

   // Outputs are decoded from the next position so they line up with the state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         pass_q    <= '0;
         pre_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         ice_q     <= 1'b0;
         cb_q      <= 1'b1;
         abs_q     <= 2'd0;
         cr_q      <= 1'b0;
         ri_q      <= 1'b0;
         region_q  <= REG_NONE;
         col_out_q <= '0;
         row_out_q <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         pass_q  <= pass_d;
         pre_q   <= pre_d;
         if (hold) begin
            valid_q <= 1'b0;
         end else begin
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            valid_q   <= (region_d != REG_NONE);
            ice_q     <= (state_d == S_PRE);
            cb_q      <= (state_d == S_PRE) ? (pre_d < PRE_HALF) : pat_cb;
            abs_q     <= pat_abs;
            cr_q      <= pat_cr;
            ri_q      <= pat_ri;
            region_q  <= region_d;
            col_out_q <= (region_d != REG_NONE) ? col_d : '0;
            row_out_q <= (region_d != REG_NONE) ? row_d : '0;
         end
      end
   end

   assign busy                = busy_q;
   assign done                = done_q;
   assign out_valid           = valid_q;
   assign in_curr_enable      = ice_q;
   assign cb_select           = cb_q;
   assign abs_control         = abs_q;
   assign change_ref          = cr_q;
   assign ref_input_control   = ri_q;
   assign region              = region_q;
   assign search_column_count = col_out_q;
   assign search_row_count    = row_out_q;

endmodule
